processor: RTL and testbench
============================

PROCESSOR -- requirements
Module: processor

Interface
REQ-001 clock  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; low forces reset state immediately, release is synchronous to clock.
REQ-003 address_imem  out  32  instruction word address (PC); external ROM has a registered read, so q_imem is valid one cycle after the address is presented.
REQ-004 q_imem  in  32  instruction word from ROM.
REQ-005 ctrl_writeEnable  out  1  regfile write strobe; the regfile writes on the rising edge while high.
REQ-006 ctrl_writeReg  out  5  regfile destination index.
REQ-007 ctrl_readRegA / ctrl_readRegB  out  5 each  regfile read indices.
REQ-008 data_writeReg  out  32  regfile write data.
REQ-009 data_readRegA / data_readRegB  in  32 each  combinational regfile read data.
REQ-010 wren  out  1  RAM write enable; the RAM writes on the rising edge while high.
REQ-011 address_dmem  out  32  RAM word address; RAM read is registered (1-cycle latency).
REQ-012 data  out  32  RAM write data.
REQ-013 q_dmem  in  32  RAM read data.

Function
REQ-014 Encoding: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], imm[16:0] sign-extended to 32 bits, target T[26:0] zero-extended.
REQ-015 Three-state FSM:
- FETCH (drive address_imem=PC) -> EXEC
- EXEC -> LOAD for lw, else -> FETCH
- LOAD -> FETCH
Latency: 2 cycles per instruction, 3 for lw.
REQ-016 ctrl_writeEnable and wren SHALL be high only in EXEC or LOAD, for exactly one cycle per instruction; the write is suppressed when the destination is r0.
REQ-017 R-type (opcode 00000), rd <= result, by aluop:
- add 00000; sub 00001; and 00010; or 00011
- sll 00100, sra 00101, shift of $rs by shamt
- mul 00110, low 32 bits of the signed product
- div 00111, signed quotient truncated toward zero
- unlisted aluop: no write.
REQ-018 Exceptions: write r30 instead of rd, with rd unchanged:
- add signed overflow -> 1; addi -> 2; sub -> 3
- mul, when the 64-bit product does not fit in 32 signed bits -> 4
- div by zero -> 5.
REQ-019 addi (00101): rd <= $rs + imm.
REQ-020 sw (00111): in EXEC, address_dmem = $rs + imm, data = $rd, wren = 1.
REQ-021 lw (01000): in EXEC, address_dmem = $rs + imm; in LOAD, rd <= q_dmem.
REQ-022 j (00001): PC <= T.
REQ-023 jal (00011): r31 <= PC+1 and PC <= T.
REQ-024 jr (00100): PC <= $rd.
REQ-025 bne (00010): if $rd != $rs, PC <= PC+1+imm.
REQ-026 blt (00110): if $rd < $rs (signed), PC <= PC+1+imm.
REQ-027 setx (10101): r30 <= T.
REQ-028 bex (10110): if r30 != 0, PC <= T.
REQ-029 All other opcodes execute as nop.
REQ-030 PC update:
- Default PC <= PC+1, 32-bit wrap-around.
- PC updates at the end of EXEC; for lw, at the end of LOAD.
REQ-031 Read-port mapping:
- R-type: A=rs, B=rt
- addi/lw: A=rs
- sw: A=rs, B=rd
- bne/blt: A=rd, B=rs
- jr: A=rd
- bex: A=30.
REQ-032 Idle outputs: wren=0; ctrl_writeEnable=0; data and address_dmem SHALL hold their last value or 0.

Reset
REQ-033 While reset is low:
- PC=0, state=FETCH
- ctrl_writeEnable=0, wren=0
- ctrl_writeReg=0, data_writeReg=0, address_imem=0.
REQ-034 Reset asserted in EXEC or LOAD SHALL abort the instruction with no register or memory write; execution restarts from PC 0.
REQ-035 Regfile and memory contents are not cleared by the processor.

Verification
REQ-036 Release reset; mem[0] = addi $1,$0,5 -> at the 2nd rising edge ctrl_writeEnable=1, ctrl_writeReg=1, data_writeReg=5; PC=1 afterwards.
REQ-037 $1=0x7FFFFFFF, $2=1, add $3,$1,$2 -> r30=1, r3 unchanged; sub $3,$1,$2 yields 0x7FFFFFFE with no exception.
REQ-038 $1=5; sw $1,4($0); lw $2,4($0) -> wren high for 1 cycle with address_dmem=4, data=5; r2=5 written in LOAD (3rd cycle of lw).
REQ-039 $1=6, $2=7: mul -> 42; div $2/$1 -> 1; $1=-7 div by $2 -> -1; div by $0 -> r30=5, rd unchanged.
REQ-040 Control flow:
- jal 10 at PC 3 -> r31=4, next fetch address 10.
- jr $31 -> fetch address 4.
- bne with $rd != $rs and imm=-2 at PC 5 -> fetch address 4.
- setx 7; bex 20 -> fetch address 20.
REQ-041 Assert reset low during LOAD of a lw -> no regfile write; outputs at reset values immediately; first fetch after release is address 0.

Source files
------------

// File: rtl/processor.sv
// processor: multi-cycle (FETCH/EXEC/LOAD) 32-bit core.
// Ports:
//   clock, reset          - rising-edge clock, async active-low reset
//   address_imem, q_imem  - instruction ROM address (PC) / registered read data
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg - regfile write port
//   ctrl_readRegA/B, data_readRegA/B               - regfile read ports (comb data)
//   wren, address_dmem, data, q_dmem               - data RAM port (registered read)
module processor (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] address_imem,
  input  logic [31:0] q_imem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic        wren,
  output logic [31:0] address_dmem,
  output logic [31:0] data,
  input  logic [31:0] q_dmem
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_LOAD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;       // lw destination carried into LOAD
  logic [31:0] addr_q, addr_d;   // last RAM address, held while idle
  logic [31:0] wdata_q, wdata_d; // last RAM write data, held while idle

  // instruction fields
  logic [4:0]  opc, rd, rs, rt, shamt, aluop;
  logic [31:0] imm, tgt, a, b, pc_inc;
  assign opc    = q_imem[31:27];
  assign rd     = q_imem[26:22];
  assign rs     = q_imem[21:17];
  assign rt     = q_imem[16:12];
  assign shamt  = q_imem[11:7];
  assign aluop  = q_imem[6:2];
  assign imm    = {{15{q_imem[16]}}, q_imem[16:0]};
  assign tgt    = {5'b0, q_imem[26:0]};
  assign a      = data_readRegA;
  assign b      = data_readRegB;
  assign pc_inc = pc_q + 32'd1;

  // datapath
  logic [31:0]        sum, dif, addi_r, quot;
  logic signed [63:0] prod;
  logic               add_ovf, sub_ovf, addi_ovf, mul_ovf;
  assign sum      = a + b;
  assign dif      = a - b;
  assign addi_r   = a + imm;
  assign add_ovf  = (a[31] == b[31]) && (sum[31] != a[31]);
  assign sub_ovf  = (a[31] != b[31]) && (dif[31] != a[31]);
  assign addi_ovf = (a[31] == imm[31]) && (addi_r[31] != a[31]);
  assign prod     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign mul_ovf  = prod[63:32] != {32{prod[31]}};
  // divide by -1 done as negation so MIN/-1 wraps deterministically
  assign quot     = (b == 32'd0)  ? 32'd0 :
                    (b == '1)     ? (32'd0 - a) :
                    32'($signed(a) / $signed(b));

  logic        do_wr;
  logic [4:0]  wreg;
  logic [31:0] wval;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    do_wr   = 1'b0;
    wreg    = 5'd0;
    wval    = 32'd0;
    wren    = 1'b0;
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
    unique case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (opc)
          5'b00000: begin
            ctrl_readRegA = rs;
            ctrl_readRegB = rt;
            do_wr = 1'b1;
            wreg  = rd;
            case (aluop)
              5'b00000: if (add_ovf) begin wreg = 5'd30; wval = 32'd1; end else wval = sum;
              5'b00001: if (sub_ovf) begin wreg = 5'd30; wval = 32'd3; end else wval = dif;
              5'b00010: wval = a & b;
              5'b00011: wval = a | b;
              5'b00100: wval = a << shamt;
              5'b00101: wval = 32'($signed(a) >>> shamt);
              5'b00110: if (mul_ovf) begin wreg = 5'd30; wval = 32'd4; end else wval = prod[31:0];
              5'b00111: if (b == 32'd0) begin wreg = 5'd30; wval = 32'd5; end else wval = quot;
              default:  do_wr = 1'b0;
            endcase
          end
          5'b00101: begin
            ctrl_readRegA = rs;
            do_wr = 1'b1;
            if (addi_ovf) begin wreg = 5'd30; wval = 32'd2; end
            else begin wreg = rd; wval = addi_r; end
          end
          5'b00111: begin
            ctrl_readRegA = rs;
            ctrl_readRegB = rd;
            addr_d  = addi_r;
            wdata_d = b;
            wren    = 1'b1;
          end
          5'b01000: begin
            ctrl_readRegA = rs;
            addr_d  = addi_r;
            rd_d    = rd;
            state_d = S_LOAD;
            pc_d    = pc_q;   // advances at the end of LOAD instead
          end
          5'b00001: pc_d = tgt;
          5'b00011: begin
            do_wr = 1'b1; wreg = 5'd31; wval = pc_inc; pc_d = tgt;
          end
          5'b00100: begin
            ctrl_readRegA = rd;
            pc_d = a;
          end
          5'b00010: begin
            ctrl_readRegA = rd;
            ctrl_readRegB = rs;
            if (a != b) pc_d = pc_inc + imm;
          end
          5'b00110: begin
            ctrl_readRegA = rd;
            ctrl_readRegB = rs;
            if ($signed(a) < $signed(b)) pc_d = pc_inc + imm;
          end
          5'b10101: begin
            do_wr = 1'b1; wreg = 5'd30; wval = tgt;
          end
          5'b10110: begin
            ctrl_readRegA = 5'd30;
            if (a != 32'd0) pc_d = tgt;
          end
          default: ;
        endcase
      end
      S_LOAD: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        do_wr   = 1'b1;
        wreg    = rd_q;
        wval    = q_dmem;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign address_imem     = pc_q;
  assign ctrl_writeEnable = do_wr && (wreg != 5'd0);
  assign ctrl_writeReg    = wreg;
  assign data_writeReg    = wval;
  assign address_dmem     = addr_d;
  assign data             = wdata_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= 32'd0;
      rd_q    <= 5'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_processor.sv
module tb_processor;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_imem, q_imem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        wren;
  logic [31:0] address_dmem, data, q_dmem;

  processor dut (
    .clock(clock), .reset(reset),
    .address_imem(address_imem), .q_imem(q_imem),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .wren(wren), .address_dmem(address_dmem), .data(data), .q_dmem(q_dmem)
  );

  always #5 clock = ~clock;

  // memories and regfile around the core
  logic [31:0] rom [64];
  logic [31:0] ram [64];
  logic [31:0] rf  [32];
  initial q_imem = '0;
  initial q_dmem = '0;
  always @(posedge clock) q_imem <= rom[address_imem[5:0]];
  always @(posedge clock) begin
    q_dmem <= ram[address_dmem[5:0]];
    if (wren) ram[address_dmem[5:0]] <= data;
  end
  always @(posedge clock) if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : rf[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : rf[ctrl_readRegB];

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard of expected writes, in program order
  typedef struct { bit mem; logic [31:0] addr; logic [31:0] val; } ev_t;
  ev_t sb[$];
  function automatic void exp_reg(input logic [4:0] r, input logic [31:0] v);
    ev_t e; e.mem = 1'b0; e.addr = {27'd0, r}; e.val = v; sb.push_back(e);
  endfunction
  function automatic void exp_mem(input logic [31:0] ad, input logic [31:0] v);
    ev_t e; e.mem = 1'b1; e.addr = ad; e.val = v; sb.push_back(e);
  endfunction

  always @(negedge clock) begin
    if (ctrl_writeEnable || wren) begin
      if (sb.size() == 0) chk("sb_unexpected_write", 32'(sb.size()), 32'd1);
      else begin
        ev_t e;
        e = sb.pop_front();
        chk("sb_kind", {31'd0, wren}, {31'd0, e.mem});
        if (wren) begin
          chk("sb_mem_addr", address_dmem, e.addr);
          chk("sb_mem_data", data, e.val);
        end else begin
          chk("sb_reg_idx", {27'd0, ctrl_writeReg}, e.addr);
          chk("sb_reg_data", data_writeReg, e.val);
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs, rt, sh, alu);
    return {5'b00000, rd, rs, rt, sh, alu, 2'b00};
  endfunction
  function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
    return {op, t};
  endfunction

  // hold reset, clear memories; caller then loads program and expectations
  task automatic clear_all();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin rom[i] = '0; ram[i] = '0; end
    for (int i = 0; i < 32; i++) rf[i] = '0;
  endtask
  task automatic run(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
    #1 chk("sb_drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    // reset state
    clear_all();
    #1;
    chk("rst_address_imem", address_imem, 32'd0);
    chk("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("rst_wren", {31'd0, wren}, 32'd0);
    chk("rst_wreg", {27'd0, ctrl_writeReg}, 32'd0);
    chk("rst_wdata", data_writeReg, 32'd0);

    // first instruction timing: addi $1,$0,5
    clear_all();
    rom[0] = enc_i(5'b00101, 5'd1, 5'd0, 17'd5);
    exp_reg(1, 32'd5);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("addi_we_2nd_edge", {31'd0, ctrl_writeEnable}, 32'd1);
    chk("addi_wreg", {27'd0, ctrl_writeReg}, 32'd1);
    chk("addi_wdata", data_writeReg, 32'd5);
    @(posedge clock); #1;
    chk("pc_after_addi", address_imem, 32'd1);
    run(2);

    // overflow exceptions
    clear_all();
    rf[1] = 32'h7FFF_FFFF; rf[2] = 32'd1; rf[3] = 32'h33; rf[6] = 32'h8000_0000;
    rom[0] = enc_r(5'd3, 5'd1, 5'd2, 5'd0, 5'b00000); exp_reg(30, 32'd1);
    rom[1] = enc_r(5'd4, 5'd1, 5'd2, 5'd0, 5'b00001); exp_reg(4, 32'h7FFF_FFFE);
    rom[2] = enc_i(5'b00101, 5'd5, 5'd1, 17'd1);      exp_reg(30, 32'd2);
    rom[3] = enc_r(5'd7, 5'd6, 5'd2, 5'd0, 5'b00001); exp_reg(30, 32'd3);
    run(12);
    chk("add_ovf_r3_kept", rf[3], 32'h33);

    // store then load
    clear_all();
    rf[1] = 32'd5;
    rom[0] = enc_i(5'b00111, 5'd1, 5'd0, 17'd4); exp_mem(32'd4, 32'd5);
    rom[1] = enc_i(5'b01000, 5'd2, 5'd0, 17'd4); exp_reg(2, 32'd5);
    rom[2] = enc_i(5'b00101, 5'd3, 5'd2, 17'd1); exp_reg(3, 32'd6);
    run(12);

    // R-type ALU, mul/div and their exceptions
    clear_all();
    rf[1] = 32'd6; rf[2] = 32'd7; rf[5] = 32'hFFFF_FFF9; rf[7] = 32'h77; rf[8] = 32'h0001_0000;
    rom[0] = enc_r(5'd3,  5'd1, 5'd2, 5'd0, 5'b00110); exp_reg(3, 32'd42);
    rom[1] = enc_r(5'd4,  5'd2, 5'd1, 5'd0, 5'b00111); exp_reg(4, 32'd1);
    rom[2] = enc_r(5'd6,  5'd5, 5'd2, 5'd0, 5'b00111); exp_reg(6, 32'hFFFF_FFFF);
    rom[3] = enc_r(5'd7,  5'd2, 5'd0, 5'd0, 5'b00111); exp_reg(30, 32'd5);
    rom[4] = enc_r(5'd9,  5'd8, 5'd8, 5'd0, 5'b00110); exp_reg(30, 32'd4);
    rom[5] = enc_r(5'd10, 5'd1, 5'd2, 5'd0, 5'b00010); exp_reg(10, 32'd6);
    rom[6] = enc_r(5'd11, 5'd1, 5'd2, 5'd0, 5'b00011); exp_reg(11, 32'd7);
    rom[7] = enc_r(5'd12, 5'd1, 5'd0, 5'd3, 5'b00100); exp_reg(12, 32'd48);
    rom[8] = enc_r(5'd13, 5'd5, 5'd0, 5'd1, 5'b00101); exp_reg(13, 32'hFFFF_FFFC);
    rom[9] = enc_r(5'd14, 5'd1, 5'd2, 5'd0, 5'b01000);  // unlisted aluop: no write
    rom[10] = enc_r(5'd0, 5'd1, 5'd2, 5'd0, 5'b00000);  // r0 destination: no write
    run(26);
    chk("div0_r7_kept", rf[7], 32'h77);

    // control flow; each landing address writes a marker
    clear_all();
    rf[3] = 32'd2; rf[10] = 32'hFFFF_FFFF; rf[11] = 32'd1;
    rom[3]  = enc_j(5'b00011, 27'd10);                 exp_reg(31, 32'd4);
    rom[10] = enc_i(5'b00100, 5'd31, 5'd0, 17'd0);
    rom[4]  = enc_i(5'b00101, 5'd2, 5'd2, 17'd1);      exp_reg(2, 32'd1);
    rom[5]  = enc_i(5'b00010, 5'd2, 5'd3, 17'h1FFFE);  exp_reg(2, 32'd2);
    rom[6]  = enc_j(5'b10101, 27'd7);                  exp_reg(30, 32'd7);
    rom[7]  = enc_j(5'b10110, 27'd20);
    rom[8]  = enc_i(5'b00101, 5'd9, 5'd0, 17'h0BAD);
    rom[20] = enc_i(5'b00101, 5'd9, 5'd0, 17'd32);     exp_reg(9, 32'd32);
    rom[21] = enc_i(5'b00110, 5'd10, 5'd11, 17'd1);
    rom[22] = enc_i(5'b00101, 5'd12, 5'd0, 17'd22);
    rom[23] = enc_i(5'b00101, 5'd12, 5'd0, 17'd23);    exp_reg(12, 32'd23);
    rom[24] = enc_j(5'b00001, 27'd24);
    run(50);

    // reset during LOAD aborts the load
    clear_all();
    ram[4] = 32'h55;
    rom[0] = enc_i(5'b01000, 5'd2, 5'd0, 17'd4);
    exp_reg(2, 32'h55);  // only the re-executed lw after release writes
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("abort_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("abort_wreg", {27'd0, ctrl_writeReg}, 32'd0);
    chk("abort_wdata", data_writeReg, 32'd0);
    chk("abort_pc", address_imem, 32'd0);
    @(posedge clock); #1;
    chk("abort_rf2_kept", rf[2], 32'd0);
    run(8);
    chk("reload_rf2", rf[2], 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
